// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command controller.
//   state_e        : controller FSM states
//   CMD_*_BIT      : command-word flag positions, counted down from the word MSB
//   STAT_*         : status register bit positions
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrite,
    StRead,
    StStream
  } state_e;

  // Flag position = WORD_SIZE - CMD_*_BIT (write is the MSB, stream the next bit down).
  localparam int unsigned CMD_WR_BIT     = 1;
  localparam int unsigned CMD_STREAM_BIT = 2;

  localparam int unsigned STAT_OVR    = 0;
  localparam int unsigned STAT_STREAM = 1;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Pixel stream bus from the command controller to the grayscale/Sobel pipeline.
//   pixel       : streamed pixel word
//   pixel_valid : one-cycle pixel strobe (issued regardless of pixel_ready)
//   pixel_ready : pipeline ready
//   frame_start : one-cycle pulse on entry into a stream burst
interface spi_cmd_ctrl_if #(
  parameter int unsigned WORD_SIZE = 8
) ();

  logic [WORD_SIZE-1:0] pixel;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic                 frame_start;

  modport master (
    output pixel,
    output pixel_valid,
    output frame_start,
    input  pixel_ready
  );

  modport slave (
    input  pixel,
    input  pixel_valid,
    input  frame_start,
    output pixel_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser into clk_i.
//   clk_i, reset_i : destination clock, synchronous active-high reset
//   d              : asynchronous input
//   q              : synchronised output (RESET_VAL while in reset)
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller (clk_i domain).
// Synchronises the SPI core's cs/word-complete flags, decodes the first word after select
// as a command (write / read / stream + start address), then services a burst:
//   clk_i, reset_i  : system clock, synchronous active-high reset
//   cs_i            : async chip select, high = deselected
//   word_done_i     : async word-complete flag from the SPI core
//   word_i          : received word, stable while word_done_i is high
//   data_tx_o       : word the SPI core sends on the next transfer
//   cfg_o           : flattened config registers, reg0 in the LSBs
//   cfg_wr_o        : one-cycle pulse per register write, cfg_addr_o = written address
//   pix             : pixel stream bus (master side)
//   busy_o          : high whenever the FSM is not idle
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = 8,
  parameter int unsigned          NUM_REGS  = 4,
  parameter int unsigned          ADDR_W    = $clog2(NUM_REGS),
  parameter logic [WORD_SIZE-1:0] CFG_RESET = '0
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              cs_i,
  input  logic                              word_done_i,
  input  logic [WORD_SIZE-1:0]              word_i,
  output logic [WORD_SIZE-1:0]              data_tx_o,
  output logic [(NUM_REGS-1)*WORD_SIZE-1:0] cfg_o,
  output logic                              cfg_wr_o,
  output logic [ADDR_W-1:0]                 cfg_addr_o,
  spi_cmd_ctrl_if.master                    pix,
  output logic                              busy_o
);

  localparam logic [ADDR_W-1:0] StatAddr = ADDR_W'(NUM_REGS - 1);

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == StatAddr) ? '0 : a + 1'b1;
  endfunction

  // Synchronisers; cs resets to deselected so nothing starts until a real select is seen.
  logic cs_s, done_s, done_q, word_ev;

  sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (cs_i),
    .q       (cs_s)
  );

  sync_2ff #(.RESET_VAL(1'b0)) u_done_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (word_done_i),
    .q       (done_s)
  );

  assign word_ev = done_s & ~done_q;

  state_e                                state_q, state_d;
  logic [ADDR_W-1:0]                     ptr_q, ptr_d;
  logic [NUM_REGS-2:0][WORD_SIZE-1:0]    cfg_q, cfg_d;
  logic                                  ovr_q, ovr_d;
  logic [WORD_SIZE-1:0]                  data_tx_q, data_tx_d;
  logic                                  cfg_wr_q, cfg_wr_d;
  logic [ADDR_W-1:0]                     cfg_addr_q, cfg_addr_d;
  logic [WORD_SIZE-1:0]                  pixel_q, pixel_d;
  logic                                  pixel_valid_q, pixel_valid_d;
  logic                                  frame_start_q, frame_start_d;

  logic [WORD_SIZE-1:0] status, rd_data;
  logic [ADDR_W-1:0]    cmd_addr, rd_addr;
  logic                 cmd_wr, cmd_stream, load_tx;

  assign cmd_addr   = word_i[ADDR_W-1:0];
  assign cmd_wr     = word_i[WORD_SIZE-CMD_WR_BIT];
  assign cmd_stream = word_i[WORD_SIZE-CMD_STREAM_BIT];

  always_comb begin
    status              = '0;
    status[STAT_OVR]    = ovr_q;
    status[STAT_STREAM] = (state_q == StStream);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state; deselect wins from any state.
  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StCmd;
        StCmd: begin
          if (word_ev) begin
            if (cmd_stream)  state_d = StStream;
            else if (cmd_wr) state_d = StWrite;
            else             state_d = StRead;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs and burst datapath.
  always_comb begin
    ptr_d         = ptr_q;
    cfg_d         = cfg_q;
    ovr_d         = ovr_q;
    cfg_wr_d      = 1'b0;
    cfg_addr_d    = cfg_addr_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    frame_start_d = 1'b0;
    rd_addr       = ptr_q;
    load_tx       = 1'b0;

    if (word_ev && !cs_s) begin
      case (state_q)
        StCmd: begin
          ptr_d = cmd_addr;
          if (cmd_stream) begin
            frame_start_d = 1'b1;
          end else if (!cmd_wr) begin
            // Read: the first register goes out on the very next word.
            rd_addr = cmd_addr;
            load_tx = 1'b1;
            ptr_d   = wrap_inc(cmd_addr);
          end
        end
        StWrite: begin
          cfg_wr_d   = 1'b1;
          cfg_addr_d = ptr_q;
          if (ptr_q == StatAddr) begin
            if (word_i[STAT_OVR]) ovr_d = 1'b0;
          end else begin
            cfg_d[ptr_q] = word_i;
          end
          ptr_d = wrap_inc(ptr_q);
        end
        StRead: begin
          load_tx = 1'b1;
          ptr_d   = wrap_inc(ptr_q);
        end
        StStream: begin
          pixel_d       = word_i;
          pixel_valid_d = 1'b1;
        end
        default: ;
      endcase
    end

    // Placed last so a same-cycle overrun beats a write-1-to-clear.
    if (pixel_valid_q && !pix.pixel_ready) ovr_d = 1'b1;
  end

  always_comb begin
    rd_data = (rd_addr == StatAddr) ? status : cfg_q[rd_addr];
    if (load_tx)                 data_tx_d = rd_data;
    else if (state_d == StRead)  data_tx_d = data_tx_q;
    else                         data_tx_d = status;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_q        <= 1'b0;
      ptr_q         <= '0;
      cfg_q         <= {(NUM_REGS-1){CFG_RESET}};
      ovr_q         <= 1'b0;
      data_tx_q     <= '0;
      cfg_wr_q      <= 1'b0;
      cfg_addr_q    <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      done_q        <= done_s;
      ptr_q         <= ptr_d;
      cfg_q         <= cfg_d;
      ovr_q         <= ovr_d;
      data_tx_q     <= data_tx_d;
      cfg_wr_q      <= cfg_wr_d;
      cfg_addr_q    <= cfg_addr_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign data_tx_o       = data_tx_q;
  assign cfg_o           = cfg_q;
  assign cfg_wr_o        = cfg_wr_q;
  assign cfg_addr_o      = cfg_addr_q;
  assign pix.pixel       = pixel_q;
  assign pix.pixel_valid = pixel_valid_q;
  assign pix.frame_start = frame_start_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: an SPI-core stand-in drives words, a transaction-level model
// predicts register writes, pixels, frame starts and transmit words, and a monitor
// pops the expectations whenever the DUT strobes an output.
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset_i, cs_i, word_done_i;
  logic [7:0] word_i, data_tx_o;
  logic [23:0] cfg_o;
  logic       cfg_wr_o, busy_o;
  logic [1:0] cfg_addr_o;

  spi_cmd_ctrl_if #(.WORD_SIZE(8)) pix_bus ();

  spi_cmd_ctrl #(
    .WORD_SIZE (8),
    .NUM_REGS  (4),
    .ADDR_W    (2),
    .CFG_RESET (8'h00)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cs_i        (cs_i),
    .word_done_i (word_done_i),
    .word_i      (word_i),
    .data_tx_o   (data_tx_o),
    .cfg_o       (cfg_o),
    .cfg_wr_o    (cfg_wr_o),
    .cfg_addr_o  (cfg_addr_o),
    .pix         (pix_bus),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef enum {MIdle, MCmd, MWrite, MRead, MStream} mode_t;
  typedef struct { logic [1:0] addr; logic [23:0] cfg; } wr_t;

  logic [7:0] regs [3];
  logic       ovr;
  mode_t      mode;
  int         ptr;

  wr_t        wr_q[$];
  logic [7:0] pix_q[$];
  int         fs_exp;
  logic [7:0] tx_exp;
  bit         tx_pending;

  function automatic logic [7:0] stat(input bit streaming);
    return {6'b0, streaming, ovr};
  endfunction

  function automatic logic [7:0] rd(input int a);
    return (a == 3) ? stat(1'b0) : regs[a];
  endfunction

  function automatic logic [23:0] cfgvec();
    return {regs[2], regs[1], regs[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) regs[i] = 8'h00;
    ovr = 1'b0; mode = MIdle; ptr = 0; tx_pending = 1'b0;
  endtask

  task automatic model_word(input logic [7:0] w, input bit ready);
    wr_t e;
    case (mode)
      MCmd: begin
        if (w[6]) begin
          mode = MStream; fs_exp++; tx_exp = stat(1'b1);
        end else if (w[7]) begin
          mode = MWrite; ptr = int'(w[1:0]); tx_exp = stat(1'b0);
        end else begin
          mode = MRead; tx_exp = rd(int'(w[1:0])); ptr = (int'(w[1:0]) + 1) % 4;
        end
      end
      MWrite: begin
        if (ptr == 3) begin
          if (w[0]) ovr = 1'b0;
        end else begin
          regs[ptr] = w;
        end
        e.addr = 2'(ptr); e.cfg = cfgvec();
        wr_q.push_back(e);
        ptr = (ptr + 1) % 4;
        tx_exp = stat(1'b0);
      end
      MRead: begin
        tx_exp = rd(ptr); ptr = (ptr + 1) % 4;
      end
      MStream: begin
        pix_q.push_back(w);
        if (!ready) ovr = 1'b1;
        tx_exp = stat(1'b1);
      end
      default: ;
    endcase
    tx_pending = 1'b1;
  endtask

  // ---------------- SPI core stand-in ----------------
  task automatic check_tx();
    if (tx_pending) chk("data_tx", 32'(data_tx_o), 32'(tx_exp));
  endtask

  task automatic begin_txn();
    cs_i = 1'b0;
    mode = MCmd;
    repeat (6) @(posedge clk);
    tx_exp = stat(1'b0);
    tx_pending = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit ready);
    check_tx();
    word_i = w;
    pix_bus.pixel_ready = ready;
    model_word(w, ready);
    #2 word_done_i = 1'b1;
    repeat (5) @(posedge clk);
    #2 word_done_i = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic end_txn();
    check_tx();
    cs_i = 1'b1;
    mode = MIdle;
    tx_pending = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " data_tx"}, 32'(data_tx_o), 32'h0);
    chk({tag, " cfg"}, 32'(cfg_o), 32'h0);
    chk({tag, " cfg_wr"}, 32'(cfg_wr_o), 32'h0);
    chk({tag, " cfg_addr"}, 32'(cfg_addr_o), 32'h0);
    chk({tag, " pixel"}, 32'(pix_bus.pixel), 32'h0);
    chk({tag, " pixel_valid"}, 32'(pix_bus.pixel_valid), 32'h0);
    chk({tag, " frame_start"}, 32'(pix_bus.frame_start), 32'h0);
    chk({tag, " busy"}, 32'(busy_o), 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset_i) begin
      if (cfg_wr_o) begin
        if (wr_q.size() == 0) begin
          chk("unexpected cfg_wr", 32'(cfg_addr_o), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("cfg_addr", 32'(cfg_addr_o), 32'(e.addr));
          chk("cfg after write", 32'(cfg_o), 32'(e.cfg));
        end
      end
      if (pix_bus.pixel_valid) begin
        if (pix_q.size() == 0) begin
          chk("unexpected pixel", 32'(pix_bus.pixel), 32'hFFFF_FFFF);
        end else begin
          logic [7:0] p;
          p = pix_q.pop_front();
          chk("pixel", 32'(pix_bus.pixel), 32'(p));
        end
      end
      if (pix_bus.frame_start) begin
        chk("frame_start expected", 32'(fs_exp > 0), 32'h1);
        if (fs_exp > 0) fs_exp--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cmd;
    int n;
    fs_exp = 0;
    model_reset();
    reset_i = 1'b1; cs_i = 1'b1; word_done_i = 1'b0; word_i = 8'h00;
    pix_bus.pixel_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("power-on");
    reset_i = 1'b0;
    repeat (4) @(posedge clk);

    // Write burst from address 0.
    begin_txn();
    send_word(8'h80, 1'b1); send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1); send_word(8'h33, 1'b1);
    end_txn();
    chk("cfg after write burst", 32'(cfg_o), 32'h0033_2211);

    // Read burst from reg1, running into the status register.
    begin_txn();
    send_word(8'h01, 1'b1); send_word(8'h00, 1'b1); send_word(8'h00, 1'b1);
    end_txn();

    // Stream with an overrun, then clear it through the status register.
    begin_txn();
    send_word(8'h40, 1'b1); send_word(8'h10, 1'b1); send_word(8'h20, 1'b0);
    chk("status after overrun", 32'(data_tx_o), 32'h03);
    end_txn();
    begin_txn();
    send_word(8'h83, 1'b1); send_word(8'h01, 1'b1);
    end_txn();
    chk("overrun cleared", 32'(data_tx_o[0]), 32'h0);

    // Deselect mid-burst; the next first word is a command again.
    begin_txn();
    send_word(8'h80, 1'b1); send_word(8'h55, 1'b1);
    end_txn();
    begin_txn();
    send_word(8'h01, 1'b1); send_word(8'h00, 1'b1);
    end_txn();
    chk("reg0 after abort", 32'(cfg_o[7:0]), 32'h55);

    // Overrun, then a write burst wrapping 2 -> 3 -> 0.
    begin_txn();
    send_word(8'h40, 1'b1); send_word(8'h99, 1'b0);
    end_txn();
    begin_txn();
    send_word(8'h82, 1'b1); send_word(8'h44, 1'b1);
    send_word(8'h01, 1'b1); send_word(8'h66, 1'b1);
    end_txn();
    chk("cfg after wrap", 32'(cfg_o), 32'h0044_2266);

    // Reset in the middle of a stream burst.
    begin_txn();
    send_word(8'h40, 1'b1); send_word(8'h12, 1'b1);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid-stream reset");
    cs_i = 1'b1;
    reset_i = 1'b0;
    model_reset();
    repeat (6) @(posedge clk);

    // Randomised transactions.
    for (int t = 0; t < 40; t++) begin
      case ($urandom % 3)
        0:       cmd = {2'b10, 6'($urandom)};
        1:       cmd = {1'($urandom), 1'b1, 6'($urandom)};
        default: cmd = {2'b00, 6'($urandom)};
      endcase
      n = $urandom_range(0, 5);
      begin_txn();
      send_word(cmd, 1'b1);
      for (int k = 0; k < n; k++) send_word(8'($urandom), ($urandom % 4) != 0);
      end_txn();
    end

    repeat (10) @(posedge clk);
    chk("write queue drained", 32'(wr_q.size()), 32'h0);
    chk("pixel queue drained", 32'(pix_q.size()), 32'h0);
    chk("frame starts drained", 32'(fs_exp), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
